// File: rtl/delay_line_pkg.sv
// Shared helpers for the delay_line retiming block: fill-counter width and
// net data inversion through the stage chain.
package delay_line_pkg;

   function automatic int fill_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Odd number of inverting stages means the line as a whole inverts.
   function automatic logic net_inversion(input logic [31:0] mask, input int depth);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < depth; i++) acc ^= mask[i];
      return acc;
   endfunction

endpackage

// File: rtl/delay_stage.sv
// One register stage of delay_line: optional data inversion, valid tag.
// With DELAY_LINE_PARITY_EN the stage also carries a parity bit.
module delay_stage
   import delay_line_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter bit INV   = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic [WIDTH-1:0] d,
   input  logic             vd,
`ifdef DELAY_LINE_PARITY_EN
   input  logic             pd,
   output logic             pq,
`endif
   output logic [WIDTH-1:0] q,
   output logic             vq
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (clear) begin
         data_d  = '0;
         valid_d = 1'b0;
      end else if (en) begin
         data_d  = d ^ {WIDTH{INV}};
         valid_d = vd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign q  = data_q;
   assign vq = valid_q;

`ifdef DELAY_LINE_PARITY_EN
   // Inverting an odd-width word flips its parity, so track that here.
   localparam bit PAR_FLIP = INV && ((WIDTH % 2) == 1);
   logic par_q, par_d;

   always_comb begin
      par_d = par_q;
      if (clear)   par_d = 1'b0;
      else if (en) par_d = pd ^ PAR_FLIP;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) par_q <= 1'b0;
      else      par_q <= par_d;
   end

   assign pq = par_q;
`endif

endmodule

// File: rtl/delay_line.sv
// Parametrised registered delay line with per-stage inversion, stall, flush,
// valid tagging and fill/primed status. Option: DELAY_LINE_PARITY_EN.
module delay_line
   import delay_line_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter int               DEPTH    = 3,
   parameter logic [DEPTH-1:0] INV_MASK = 3'b101
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic                         clear,
   input  logic [WIDTH-1:0]             in,
   input  logic                         valid_in,
   output logic [WIDTH-1:0]             out,
   output logic                         valid_out,
   output logic                         primed,
`ifdef DELAY_LINE_PARITY_EN
   output logic                         parity_err,
`endif
   output logic [fill_width(DEPTH)-1:0] fill
);

   localparam int            FW       = fill_width(DEPTH);
   localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);

   // Element i feeds stage i; element DEPTH is the last stage output.
   logic [WIDTH-1:0] data_w [DEPTH+1];
   logic [DEPTH:0]   valid_w;
`ifdef DELAY_LINE_PARITY_EN
   logic [DEPTH:0]   par_w;
   assign par_w[0] = ^in;
`endif

   assign data_w[0]  = in;
   assign valid_w[0] = valid_in;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      delay_stage #(
         .WIDTH(WIDTH),
         .INV  (INV_MASK[i])
      ) u_stage (
         .clk  (clk),
         .rst  (rst),
         .en   (en),
         .clear(clear),
         .d    (data_w[i]),
         .vd   (valid_w[i]),
`ifdef DELAY_LINE_PARITY_EN
         .pd   (par_w[i]),
         .pq   (par_w[i+1]),
`endif
         .q    (data_w[i+1]),
         .vq   (valid_w[i+1])
      );
   end

   logic [FW-1:0] fill_q, fill_d;

   always_comb begin
      fill_d = fill_q;
      if (clear)                          fill_d = '0;
      else if (en && fill_q != FILL_MAX)  fill_d = fill_q + FW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) fill_q <= '0;
      else      fill_q <= fill_d;
   end

   assign out       = data_w[DEPTH];
   assign valid_out = valid_w[DEPTH];
   assign fill      = fill_q;
   assign primed    = (fill_q == FILL_MAX);

`ifdef DELAY_LINE_PARITY_EN
   logic perr_q, perr_d;

   always_comb begin
      perr_d = perr_q;
      if (clear)   perr_d = 1'b0;
      else if (en) perr_d = (^data_w[DEPTH] != par_w[DEPTH]) && valid_w[DEPTH];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perr_q <= 1'b0;
      else      perr_q <= perr_d;
   end

   assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_delay_line.sv
// Scoreboard bench for delay_line: two instances (even and odd inversion mask)
// share stimulus; a queue of issued valid samples is checked by a monitor.
module tb_delay_line;

   localparam int         W      = 8;
   localparam int         D      = 3;
   localparam logic [2:0] MASK_A = 3'b101;
   localparam logic [2:0] MASK_B = 3'b001;
   localparam logic       INV_A  = ^MASK_A;
   localparam logic       INV_B  = ^MASK_B;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         en = 1'b0, clear = 1'b0, valid_in = 1'b0;
   logic [W-1:0] in_s = '0;
   logic [W-1:0] out_a, out_b;
   logic         vout_a, vout_b, primed_a, primed_b;
   logic [1:0]   fill_a, fill_b;
`ifdef DELAY_LINE_PARITY_EN
   logic         perr_a, perr_b;
`endif

   always #5 clk = ~clk;

   delay_line #(.WIDTH(W), .DEPTH(D), .INV_MASK(MASK_A)) u_a (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .in(in_s), .valid_in(valid_in),
      .out(out_a), .valid_out(vout_a), .primed(primed_a),
`ifdef DELAY_LINE_PARITY_EN
      .parity_err(perr_a),
`endif
      .fill(fill_a));

   delay_line #(.WIDTH(W), .DEPTH(D), .INV_MASK(MASK_B)) u_b (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .in(in_s), .valid_in(valid_in),
      .out(out_b), .valid_out(vout_b), .primed(primed_b),
`ifdef DELAY_LINE_PARITY_EN
      .parity_err(perr_b),
`endif
      .fill(fill_b));

   typedef struct {
      logic [W-1:0] data;
      int           due;
   } sb_entry_t;

   sb_entry_t sb[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  en_cnt = 0;
   int  fill_m = 0;
   bit  shifted = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_flush();
      sb.delete();
      fill_m  = 0;
   endtask

   // Reference: a sample taken at enabled edge k leaves at enabled edge k+D-1,
   // inverted overall iff the mask has odd popcount.
   task automatic step(input logic e, input logic c, input logic [W-1:0] d, input logic v);
      en = e; clear = c; in_s = d; valid_in = v;
      @(posedge clk);
      shifted = 1'b0;
      if (rst) begin
         if (c) begin
            model_flush();
            shifted = 1'b1;
         end else if (e) begin
            en_cnt++;
            if (fill_m < D) fill_m++;
            if (v) sb.push_back('{data: d, due: en_cnt + D - 1});
            shifted = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   // Monitor
   initial begin
      forever begin
         @(negedge clk);
         chk("fill_a", 32'(fill_a), 32'(fill_m));
         chk("fill_b", 32'(fill_b), 32'(fill_m));
         chk("primed_a", 32'(primed_a), 32'(fill_m == D));
         chk("primed_b", 32'(primed_b), 32'(fill_m == D));
         if (shifted) begin
            logic exp_v;
            exp_v = (sb.size() > 0) && (sb[0].due == en_cnt);
            chk("valid_out_a", 32'(vout_a), 32'(exp_v));
            chk("valid_out_b", 32'(vout_b), 32'(exp_v));
            if (exp_v) begin
               chk("out_a", 32'(out_a), 32'(sb[0].data ^ {W{INV_A}}));
               chk("out_b", 32'(out_b), 32'(sb[0].data ^ {W{INV_B}}));
               void'(sb.pop_front());
            end
            shifted = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   task automatic chk_zero(input string tag);
      chk({tag, "_out_a"}, 32'(out_a), 32'h0);
      chk({tag, "_out_b"}, 32'(out_b), 32'h0);
      chk({tag, "_vout_a"}, 32'(vout_a), 32'h0);
      chk({tag, "_fill_a"}, 32'(fill_a), 32'h0);
      chk({tag, "_primed_a"}, 32'(primed_a), 32'h0);
   endtask

   initial begin
      // Reset held with active-looking inputs
      rst = 1'b0; en = 1'b1; in_s = 8'hFF; valid_in = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      rst = 1'b1;

      // Latency and identity
      step(1'b1, 1'b0, 8'hA5, 1'b1);
      repeat (4) step(1'b1, 1'b0, 8'h00, 1'b0);

      // Back-to-back stream
      step(1'b1, 1'b0, 8'h0F, 1'b1);
      step(1'b1, 1'b0, 8'h3C, 1'b1);
      repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);

      // Stall
      step(1'b1, 1'b0, 8'h11, 1'b1);
      step(1'b0, 1'b0, 8'h22, 1'b1);
      step(1'b0, 1'b0, 8'h33, 1'b1);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 1'b0);

      // Clear beats enable
      repeat (4) step(1'b1, 1'b0, 8'($urandom), 1'b1);
      step(1'b1, 1'b1, 8'h77, 1'b1);
      chk_zero("clear");
      repeat (4) step(1'b1, 1'b0, 8'h00, 1'b0);

      // Async reset with a valid sample sitting in stage 1
      step(1'b1, 1'b0, 8'hC3, 1'b1);
      step(1'b1, 1'b0, 8'h00, 1'b0);
      #2 rst = 1'b0;
      model_flush();
      #1 chk_zero("async_rst");
      @(negedge clk);
      rst = 1'b1;
      step(1'b1, 1'b0, 8'h5E, 1'b1);
      repeat (3) step(1'b1, 1'b0, 8'h00, 1'b0);

      // Random traffic
      for (int n = 0; n < 300; n++) begin
         step(($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0),
              8'($urandom), 1'($urandom));
      end

      repeat (D + 1) step(1'b1, 1'b0, 8'h00, 1'b0);
      chk("scoreboard_drained", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
